// File: rtl/simd_udiv_iter.sv
// simd_udiv_iter: iterative radix-2 restoring SIMD unsigned divider.
// All packed elements at the selected width produce one quotient bit per cycle.
module simd_udiv_iter #(
   parameter int MIN_WIDTH = 8,
   parameter int MAX_WIDTH = 64,
   parameter int SEW_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1,
   parameter int TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [SEW_WIDTH-1:0] sew,
   input  logic [MAX_WIDTH-1:0] dividend,
   input  logic [MAX_WIDTH-1:0] divisor,
   input  logic [TAG_WIDTH-1:0] tag_i,
   input  logic                 kill_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [MAX_WIDTH-1:0] quotient,
   output logic [MAX_WIDTH-1:0] remainder,
   output logic [TAG_WIDTH-1:0] tag_o
);
   localparam int SW = SEW_WIDTH > 1 ? $clog2(SEW_WIDTH) : 1;
   localparam int CW = $clog2(MAX_WIDTH) + 1;
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
   logic [1:0]           state;
   logic [SW-1:0]        sel, sel_r;
   logic [CW-1:0]        cnt;
   logic [MAX_WIDTH-1:0] rem_r, dvd_r, dvs_r, zm_r;
   logic [TAG_WIDTH-1:0] tag_r;
   logic [MAX_WIDTH-1:0] rem_n [SEW_WIDTH];
   logic [MAX_WIDTH-1:0] dvd_n [SEW_WIDTH];
   logic [MAX_WIDTH-1:0] zm    [SEW_WIDTH];
   assign ready_o = state == IDLE;
   assign valid_o = state == DONE;
   // Lowest set bit wins; sew=0 falls back to the full datapath width.
   always_comb begin
      sel = '0;
      for (int i = SEW_WIDTH-1; i >= 0; i--) if (sew[i]) sel = SW'(i);
   end
   // One step per candidate width; dvd_r doubles as the quotient shift register.
   for (genvar k = 0; k < SEW_WIDTH; k++) begin : g_w
      localparam int W = MAX_WIDTH >> k;
      for (genvar e = 0; e < MAX_WIDTH/W; e++) begin : g_e
         logic [W:0] diff;
         assign diff = {rem_r[e*W +: W], dvd_r[e*W+W-1]} - {1'b0, dvs_r[e*W +: W]};
         assign rem_n[k][e*W +: W] = diff[W] ? {rem_r[e*W +: W-1], dvd_r[e*W+W-1]} : diff[W-1:0];
         assign dvd_n[k][e*W +: W] = {dvd_r[e*W +: W-1], ~diff[W]};
         assign zm[k][e*W +: W] = {W{divisor[e*W +: W] == '0}};
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sel_r     <= '0;
         rem_r     <= '0;
         dvd_r     <= '0;
         dvs_r     <= '0;
         zm_r      <= '0;
         tag_r     <= '0;
         quotient  <= '0;
         remainder <= '0;
         tag_o     <= '0;
      end else if (state == IDLE) begin
         if (valid_i) begin
            state <= CALC;
            cnt   <= CW'(MAX_WIDTH >> sel);
            sel_r <= sel;
            rem_r <= '0;
            dvd_r <= dividend;
            dvs_r <= divisor;
            zm_r  <= zm[sel];
            tag_r <= tag_i;
         end
      end else if (state == CALC) begin
         if (kill_i) begin
            state <= IDLE;
         end else begin
            rem_r <= rem_n[sel_r];
            dvd_r <= dvd_n[sel_r];
            cnt   <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               state     <= DONE;
               quotient  <= dvd_n[sel_r] | zm_r;
               remainder <= rem_n[sel_r];
               tag_o     <= tag_r;
            end
         end
      end else if (kill_i || ready_i) begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_simd_udiv_iter.sv
// tb_simd_udiv_iter: directed vectors with hand-computed quotients, remainders and latencies.
module tb_simd_udiv_iter;
   logic        clk = 0, rst_n = 0, valid_i = 0, kill_i = 0, ready_i = 0;
   logic        ready_o, valid_o;
   logic [3:0]  sew = 0, tag_i = 0, tag_o;
   logic [63:0] dividend = 0, divisor = 0, quotient, remainder;
   logic [63:0] q_hold, r_hold;
   logic        seen;
   int          checks = 0, failures = 0;

   simd_udiv_iter dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .sew(sew),
      .dividend(dividend), .divisor(divisor), .tag_i(tag_i), .kill_i(kill_i),
      .valid_o(valid_o), .ready_i(ready_i), .quotient(quotient), .remainder(remainder),
      .tag_o(tag_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns just after the handshake edge.
   task automatic start(input logic [3:0] s, input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
      sew = s; dividend = a; divisor = b; tag_i = t; valid_i = 1;
      @(posedge clk);
   endtask

   // Scrambles the operand inputs to show they are only sampled at the handshake.
   task automatic wait_done(input string tag, input int lat);
      int n = 0;
      do begin
         @(negedge clk);
         valid_i = 0; kill_i = 0;
         dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom}; sew = 4'($urandom);
         n++;
      end while (!valid_o && n < 200);
      chk(tag, 64'(n), 64'(lat));
   endtask

   task automatic take();
      ready_i = 1;
      @(negedge clk);
      ready_i = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hs", {62'd0, valid_o, ready_o}, 64'b01);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_tag", 64'(tag_o), 0);
      rst_n = 1;

      start(4'b1000, 64'h6464_6464_6464_6464, 64'h0707_0707_0707_0707, 4'h3);
      wait_done("lat8", 9);
      chk("b8_q", quotient, 64'h0E0E_0E0E_0E0E_0E0E);
      chk("b8_r", remainder, 64'h0202_0202_0202_0202);
      chk("b8_tag", 64'(tag_o), 64'h3);
      take();

      start(4'b0001, 64'h1234, 64'h0, 4'h4);
      wait_done("lat64", 65);
      chk("dz64_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("dz64_r", remainder, 64'h1234);
      take();

      start(4'b0010, {32'd1000, 32'd5}, {32'd0, 32'd7}, 4'h5);
      wait_done("lat32", 33);
      chk("w32_q", quotient, {32'hFFFF_FFFF, 32'd0});
      chk("w32_r", remainder, {32'd1000, 32'd5});
      take();

      start(4'b0100, 64'hFFFF_03E8_0007_012C, 64'h0001_001E_0009_012C, 4'h9);
      wait_done("lat16", 17);
      chk("w16_q", quotient, 64'hFFFF_0021_0000_0001);
      chk("w16_r", remainder, 64'h0000_000A_0007_0000);
      q_hold = quotient; r_hold = remainder;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hs", {62'd0, valid_o, ready_o}, 64'b10);
         chk("bp_q", quotient, q_hold);
         chk("bp_r", remainder, r_hold);
         chk("bp_tag", 64'(tag_o), 64'h9);
      end
      ready_i = 1; valid_i = 1; sew = 4'b1000; tag_i = 4'hC;
      dividend = 64'hFFFF_FFFF_FFFF_FFFF; divisor = 64'h0101_0101_0101_0101;
      @(posedge clk);
      @(negedge clk);
      chk("bp_reidle", {62'd0, valid_o, ready_o}, 64'b01);
      ready_i = 0;
      @(posedge clk);
      wait_done("lat8b", 9);
      chk("max_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("max_r", remainder, 0);
      chk("max_tag", 64'(tag_o), 64'hC);
      take();

      start(4'b0001, 64'd1000000, 64'd7, 4'h6);
      @(negedge clk); valid_i = 0;
      @(negedge clk);
      @(negedge clk); kill_i = 1;
      @(negedge clk); kill_i = 0;
      chk("kill_hs", {62'd0, valid_o, ready_o}, 64'b01);
      seen = 0;
      repeat (70) begin
         @(negedge clk);
         seen |= valid_o;
      end
      chk("kill_quiet", 64'(seen), 0);
      kill_i = 1;
      start(4'b0001, 64'd1000000, 64'd7, 4'h7);
      wait_done("lat64b", 65);
      chk("post_kill_q", quotient, 64'd142857);
      chk("post_kill_r", remainder, 64'd1);
      chk("post_kill_tag", 64'(tag_o), 64'h7);
      take();

      start(4'b0010, 64'd99, 64'd4, 4'hA);
      repeat (3) begin
         @(negedge clk); valid_i = 0;
      end
      rst_n = 0;
      @(negedge clk); rst_n = 1;
      chk("mid_rst_hs", {62'd0, valid_o, ready_o}, 64'b01);
      chk("mid_rst_q", quotient, 0);
      chk("mid_rst_r", remainder, 0);
      chk("mid_rst_tag", 64'(tag_o), 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         seen |= valid_o;
      end
      chk("rst_quiet", 64'(seen), 0);

      start(4'b1010, {32'd100, 32'd9}, {32'd7, 32'd2}, 4'hB);
      wait_done("lat_mix", 33);
      chk("mix_q", quotient, {32'd14, 32'd4});
      chk("mix_r", remainder, {32'd2, 32'd1});
      take();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
